// File: rtl/regfile_vec_engine.sv
`default_nettype none
// ============================================================================
// Module      : regfile_vec_engine
// Description : Vector copy/add engine driving an external register file.
//               Streams len elements at one element per cycle: the read of
//               element i+1 overlaps the write of element i.
//               Optional macro REGFILE_VEC_SATURATE_EN makes add results
//               clamp to 2^W-1 instead of wrapping modulo 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_vec_engine #(
    parameter int M = 4,    // address bits
    parameter int N = 16,   // number of words (2^M)
    parameter int W = 8     // bits per word
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [M:0]   len,
    input  logic [M-1:0] src_a,
    input  logic [M-1:0] src_b,
    input  logic [M-1:0] dst,
    output logic         busy,
    output logic         done,
    output logic [M:0]   wr_count,
    output logic         rf_read_en_a,
    output logic         rf_read_en_b,
    output logic [M-1:0] rf_rd_addra,
    output logic [M-1:0] rf_rd_addrb,
    input  logic [W-1:0] rf_douta,
    input  logic [W-1:0] rf_doutb,
    output logic         rf_wr_enable,
    output logic [M-1:0] rf_wr_addr,
    output logic [W-1:0] rf_din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_op;
    logic [M:0]   r_len;
    logic [M:0]   r_idx;
    logic [M-1:0] r_dst;
    logic         r_busy;
    logic         r_done;
    logic [M:0]   r_wr_count;
    logic         r_read_en_a;
    logic         r_read_en_b;
    logic [M-1:0] r_rd_addra;
    logic [M-1:0] r_rd_addrb;
    logic         r_wr_enable;
    logic [M-1:0] r_wr_addr;
    logic [W-1:0] r_din;

    logic [M:0]   w_len;
    logic [M:0]   w_idx_nxt;
    logic         w_last;
    logic [W-1:0] w_add;
    logic [W-1:0] w_result;

    // Requests longer than the register file are clamped to one full pass
    assign w_len     = (len > (M+1)'(N)) ? (M+1)'(N) : len;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (w_idx_nxt == r_len);

`ifdef REGFILE_VEC_SATURATE_EN
    logic [W:0] w_sum;
    // Unsigned add with clamp on carry-out
    always_comb begin
        w_sum = {1'b0, rf_douta} + {1'b0, rf_doutb};
        w_add = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    end
`else
    // Unsigned add wrapping modulo 2^W
    always_comb begin
        w_add = rf_douta + rf_doutb;
    end
`endif

    assign w_result = r_op ? w_add : rf_douta;

    // Control FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_len       <= '0;
            r_idx       <= '0;
            r_dst       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_count  <= '0;
            r_read_en_a <= 1'b0;
            r_read_en_b <= 1'b0;
            r_rd_addra  <= '0;
            r_rd_addrb  <= '0;
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_din       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done      <= 1'b0;
                    r_wr_enable <= 1'b0;
                    if (start) begin
                        r_op       <= op;
                        r_len      <= w_len;
                        r_dst      <= dst;
                        r_idx      <= '0;
                        r_wr_count <= '0;
                        r_busy     <= 1'b1;
                        r_rd_addra <= src_a;
                        r_rd_addrb <= src_b;
                        if (w_len == '0) begin
                            // Empty command still spends one cycle before
                            // DONE so latency stays len+2 for every len
                            r_state <= S_FLUSH;
                        end else begin
                            r_state     <= S_RUN;
                            r_read_en_a <= 1'b1;
                            r_read_en_b <= op;
                        end
                    end
                end
                S_RUN: begin
                    // Capture element r_idx and present its write next cycle
                    r_wr_enable <= 1'b1;
                    r_wr_addr   <= r_dst + r_idx[M-1:0];
                    r_din       <= w_result;
                    r_wr_count  <= r_wr_count + 1'b1;
                    if (w_last) begin
                        r_state     <= S_FLUSH;
                        r_read_en_a <= 1'b0;
                        r_read_en_b <= 1'b0;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_rd_addra <= r_rd_addra + 1'b1;
                        r_rd_addrb <= r_rd_addrb + 1'b1;
                    end
                end
                S_FLUSH: begin
                    // The last write is on the bus during this cycle
                    r_wr_enable <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign wr_count     = r_wr_count;
    assign rf_read_en_a = r_read_en_a;
    assign rf_read_en_b = r_read_en_b;
    assign rf_rd_addra  = r_rd_addra;
    assign rf_rd_addrb  = r_rd_addrb;
    assign rf_wr_enable = r_wr_enable;
    assign rf_wr_addr   = r_wr_addr;
    assign rf_din       = r_din;

endmodule
`default_nettype wire

// File: tb/tb_regfile_vec_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_vec_engine
// Description : Self-checking bench for regfile_vec_engine with a behavioural
//               register file and a snapshot-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_vec_engine;
    localparam int M = 4;
    localparam int N = 16;
    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [M:0]   len = '0;
    logic [M-1:0] src_a = '0, src_b = '0, dst = '0;
    logic         busy, done;
    logic [M:0]   wr_count;
    logic         rf_read_en_a, rf_read_en_b;
    logic [M-1:0] rf_rd_addra, rf_rd_addrb;
    logic [W-1:0] rf_douta, rf_doutb;
    logic         rf_wr_enable;
    logic [M-1:0] rf_wr_addr;
    logic [W-1:0] rf_din;

    // bench-side register file and preload port
    logic [W-1:0] rf [N];
    logic         tb_we = 1'b0;
    logic [M-1:0] tb_waddr = '0;
    logic [W-1:0] tb_wdata = '0;
    logic         clr_mon = 1'b0;
    int           n_wr = 0;
    int           n_dup = 0;
    int           n_done = 0;
    logic [N-1:0] wmask = '0;

    logic [W-1:0] model [N];
    int           n_asserts = 0;
    int           n_fail = 0;

    regfile_vec_engine #(.M(M), .N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .len(len),
        .src_a(src_a), .src_b(src_b), .dst(dst),
        .busy(busy), .done(done), .wr_count(wr_count),
        .rf_read_en_a(rf_read_en_a), .rf_read_en_b(rf_read_en_b),
        .rf_rd_addra(rf_rd_addra), .rf_rd_addrb(rf_rd_addrb),
        .rf_douta(rf_douta), .rf_doutb(rf_doutb),
        .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_din(rf_din)
    );

    always #5 clk = ~clk;

    assign rf_douta = rf[rf_rd_addra];
    assign rf_doutb = rf[rf_rd_addrb];

    // register file storage plus write/done monitor
    always @(posedge clk) begin
        if (rf_wr_enable)
            rf[rf_wr_addr] <= rf_din;
        else if (tb_we)
            rf[tb_waddr] <= tb_wdata;
        if (done)
            n_done <= n_done + 1;
        if (clr_mon) begin
            n_wr  <= 0;
            n_dup <= 0;
            wmask <= '0;
        end else if (rf_wr_enable) begin
            n_wr <= n_wr + 1;
            if (wmask[rf_wr_addr]) n_dup <= n_dup + 1;
            wmask[rf_wr_addr] <= 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic preload(input int addr, input int data);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = M'(addr);
        tb_wdata = W'(data);
        @(posedge clk);
        #1 tb_we = 1'b0;
        model[addr] = W'(data);
    endtask

    // Expected memory: every element reads the pre-command snapshot
    task automatic apply(input logic o, input int l, input int a, input int b, input int d);
        logic [W-1:0] res [N];
        int s;
        for (int i = 0; i < l; i++) begin
            s = int'(model[(a + i) % N]) + int'(model[(b + i) % N]);
`ifdef REGFILE_VEC_SATURATE_EN
            if (s > MAXV) s = MAXV;
`else
            s = s % (MAXV + 1);
`endif
            res[i] = o ? W'(s) : model[(a + i) % N];
        end
        for (int i = 0; i < l; i++) model[(d + i) % N] = res[i];
    endtask

    task automatic issue(input logic o, input int l, input int a, input int b, input int d);
        @(negedge clk);
        op      = o;
        len     = (M+1)'(l);
        src_a   = M'(a);
        src_b   = M'(b);
        dst     = M'(d);
        start   = 1'b1;
        clr_mon = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        clr_mon = 1'b0;
    endtask

    // Waits for done; optionally re-pulses start while busy at cycle 'poke';
    // afterwards pulses start during DONE, which must be ignored
    task automatic wait_done(input int exp_lat, input int poke, input string tag);
        int lat = 0;
        bit got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
            if (lat == poke) dst = dst + 4'd4;
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 1);
            if (done) got = 1;
        end
        start = 1'b1;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pulse"}, 32'(done), 0);
        check({tag, "_ign_done_start"}, 32'(busy), 0);
    endtask

    task automatic compare_rf(input string tag);
        for (int i = 0; i < N; i++) check(tag, 32'(rf[i]), 32'(model[i]));
    endtask

    task automatic run_cmd(input logic o, input int l, input int a, input int b, input int d,
                           input string tag);
        issue(o, l, a, b, d);
        apply(o, l, a, b, d);
        wait_done(l + 2, 0, tag);
        check({tag, "_wrcnt"}, 32'(wr_count), l);
        check({tag, "_nwr"}, n_wr, l);
        compare_rf({tag, "_rf"});
    endtask

    initial begin
        int a, b, d, l, nd, w0;
        logic o;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wrcnt", 32'(wr_count), 0);
        check("rst_en", {29'd0, rf_read_en_a, rf_read_en_b, rf_wr_enable}, 0);
        check("rst_addr", {20'd0, rf_rd_addra, rf_rd_addrb, rf_wr_addr}, 0);
        check("rst_din", 32'(rf_din), 0);
        reset = 1'b0;

        for (int i = 0; i < N; i++) preload(i, $urandom_range(0, MAXV));

        // plain copy
        preload(0, 10); preload(1, 20); preload(2, 30); preload(3, 40);
        run_cmd(1'b0, 4, 0, 0, 8, "copy4");
        check("copy4_w11", 32'(rf[11]), 40);

        // add with overflow on the second element
        preload(0, 100); preload(1, 200); preload(4, 100); preload(5, 100);
        run_cmd(1'b1, 2, 0, 4, 12, "add2");
        check("add2_w12", 32'(rf[12]), 200);
`ifdef REGFILE_VEC_SATURATE_EN
        check("add2_w13", 32'(rf[13]), 255);
`else
        check("add2_w13", 32'(rf[13]), 44);
`endif

        // address wrap
        run_cmd(1'b0, 3, 14, 0, 2, "wrap");

        // empty command
        run_cmd(1'b0, 0, 3, 5, 9, "len0");

        // reset in the third RUN cycle of an 8-element copy
        issue(1'b0, 8, 0, 0, 8);
        nd = n_done;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_nwr_le2", 32'(n_wr <= 2), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_wrcnt", 32'(wr_count), 0);
        check("abort_wren", 32'(rf_wr_enable), 0);
        w0 = n_wr;
        for (int i = 0; i < w0; i++) model[8 + i] = model[i];
        repeat (12) @(negedge clk);
        check("abort_nodone", n_done, nd);
        check("abort_nwr_final", n_wr, w0);
        compare_rf("abort_rf");
        run_cmd(1'b1, 3, 1, 5, 10, "after_abort");

        // start re-pulsed while busy must be ignored
        issue(1'b0, 4, 4, 0, 8);
        apply(1'b0, 4, 4, 0, 8);
        wait_done(6, 2, "busy_start");
        check("busy_start_nwr", n_wr, 4);
        compare_rf("busy_start_rf");

        // full-length pass touches every word exactly once
        run_cmd(1'b0, N, 5, 0, 5, "full");
        check("full_mask", 32'(wmask), (1 << N) - 1);
        check("full_dup", n_dup, 0);

        // randomized commands with disjoint source/destination ranges
        for (int r = 0; r < 12; r++) begin
            o = 1'($urandom_range(0, 1));
            l = $urandom_range(1, 8);
            a = $urandom_range(0, N - 1);
            b = (a + $urandom_range(0, 8 - l)) % N;
            d = (a + 8) % N;
            run_cmd(o, l, a, b, d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
